// File: rtl/usart_pkg.sv
// usart_pkg: shared types for the usart library.
// Provides the frame width, the 12-bit bit-time divisor type, the RX/TX state
// enums and a helper that clamps the divisor to its smallest usable value.
package usart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned DIV_W     = 12;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef logic [DIV_W-1:0]     divisor_t;
  typedef logic [DATA_BITS-1:0] data_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // A half-bit wait of zero ticks is meaningless, so anything below 2 becomes 2.
  function automatic divisor_t clamp_div(input divisor_t d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

endpackage

// File: rtl/usart_echo_unit_if.sv
// usart_echo_unit_if: serial-side signal bundle of the echo unit.
//   serial_clock   baud reference level (sampled by comm_clock)
//   clocks_per_bit ticks per serial bit, quasi-static
//   rx_pin         serial input from the host, idle high
//   tx_pin         serial output to the host, idle high
//   rts_pin        request-to-send, active low
// master = host side, slave = echo unit.
interface usart_echo_unit_if;

  logic                serial_clock;
  usart_pkg::divisor_t clocks_per_bit;
  logic                rx_pin;
  logic                tx_pin;
  logic                rts_pin;

  modport master (
    output serial_clock,
    output clocks_per_bit,
    output rx_pin,
    input  tx_pin,
    input  rts_pin
  );

  modport slave (
    input  serial_clock,
    input  clocks_per_bit,
    input  rx_pin,
    output tx_pin,
    output rts_pin
  );

endinterface

// File: rtl/usart_echo_fifo.sv
// usart_echo_fifo: DEPTH x 8 echo buffer with wrap-around pointers.
//   clk, rst_n  clock and synchronous active-low reset
//   push        write wr_data; ignored while full
//   pop         advance read pointer; ignored while empty
//   rd_data_c   head entry (combinational view of the array)
//   full/empty  registered status flags
//   count       registered fill level, $clog2(DEPTH)+1 bits
module usart_echo_fifo
  import usart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  data_t                    wr_data,
  input  logic                     pop,
  output data_t                    rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  data_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push_c, do_pop_c;

  // Next pointers/count; push+pop together leaves the count unchanged.
  always_comb begin
    do_push_c = push && !full_q;
    do_pop_c  = pop && !empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array carries no reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/usart_echo_unit.sv
// usart_echo_unit: 8N1 loopback. Receives frames on ser.rx_pin, buffers good
// bytes in usart_echo_fifo and retransmits them on ser.tx_pin.
//   comm_clock  sole clock, rising edge
//   reset_n     synchronous active-low reset
//   ser         usart_echo_unit_if.slave (serial_clock, clocks_per_bit,
//               rx_pin in; tx_pin, rts_pin out)
module usart_echo_unit
  import usart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              comm_clock,
  input  logic              reset_n,
  usart_echo_unit_if.slave  ser
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  // Tick generator and RX synchroniser
  logic sclk_q;
  logic tick_c;
  logic rx_meta_q, rx_sync_q;

  // RX path
  rx_state_e             rx_state_q, rx_state_d;
  divisor_t              rx_cpb_q, rx_cpb_d;
  divisor_t              rx_cnt_q, rx_cnt_d;
  divisor_t              rx_cnt_inc_c;
  logic [BIT_IDX_W-1:0]  rx_bit_q, rx_bit_d;
  data_t                 rx_shift_q, rx_shift_d;
  logic                  rx_err_q, rx_err_d;
  logic                  push_q, push_d;

  // TX path
  tx_state_e             tx_state_q, tx_state_d;
  divisor_t              tx_cpb_q, tx_cpb_d;
  divisor_t              tx_cnt_q, tx_cnt_d;
  divisor_t              tx_cnt_inc_c;
  logic [BIT_IDX_W-1:0]  tx_bit_q, tx_bit_d;
  data_t                 tx_shift_q, tx_shift_d;
  logic                  tx_q, tx_d;
  logic                  pop_c;

  // FIFO and flow control
  data_t                 fifo_rd_c;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  rts_q, rts_d;

  // One-cycle tick on each sampled rising edge of serial_clock.
  assign tick_c       = ser.serial_clock && !sclk_q;
  assign rx_cnt_inc_c = rx_cnt_q + DIV_W'(1);
  assign tx_cnt_inc_c = tx_cnt_q + DIV_W'(1);

  // RX next state: half-bit start check, then mid-bit samples every bit time.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cpb_d   = rx_cpb_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_err_d   = rx_err_q;
    push_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_cpb_d   = clamp_div(ser.clocks_per_bit);
          rx_err_d   = 1'b0;
        end
      end
      RX_START: begin
        if (tick_c) begin
          rx_cnt_d = rx_cnt_inc_c;
          if (rx_cnt_inc_c == (rx_cpb_q >> 1)) begin
            rx_cnt_d = '0;
            if (!rx_sync_q) begin
              rx_state_d = RX_DATA;
              rx_bit_d   = '0;
            end else begin
              rx_state_d = RX_IDLE;
            end
          end
        end
      end
      RX_DATA: begin
        if (tick_c) begin
          rx_cnt_d = rx_cnt_inc_c;
          if (rx_cnt_inc_c == rx_cpb_q) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
            else                      rx_bit_d   = rx_bit_q + BIT_IDX_W'(1);
          end
        end
      end
      RX_STOP: begin
        // After a framing error, hold here until the line is released.
        if (rx_err_q) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
            rx_err_d   = 1'b0;
          end
        end else if (tick_c) begin
          rx_cnt_d = rx_cnt_inc_c;
          if (rx_cnt_inc_c == rx_cpb_q) begin
            rx_cnt_d = '0;
            if (rx_sync_q) begin
              push_d     = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              rx_err_d = 1'b1;
            end
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX next state; a pending byte at the end of STOP starts the next frame directly.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cpb_d   = tx_cpb_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop_c      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          tx_shift_d = fifo_rd_c;
          tx_cpb_d   = clamp_div(ser.clocks_per_bit);
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tick_c) begin
          tx_cnt_d = tx_cnt_inc_c;
          if (tx_cnt_inc_c == tx_cpb_q) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          end
        end
      end
      TX_DATA: begin
        if (tick_c) begin
          tx_cnt_d = tx_cnt_inc_c;
          if (tx_cnt_inc_c == tx_cpb_q) begin
            tx_cnt_d = '0;
            if (tx_bit_q == LAST_BIT) begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end else begin
              tx_bit_d   = tx_bit_q + BIT_IDX_W'(1);
              tx_d       = tx_shift_q[0];
              tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            end
          end
        end
      end
      TX_STOP: begin
        if (tick_c) begin
          tx_cnt_d = tx_cnt_inc_c;
          if (tx_cnt_inc_c == tx_cpb_q) begin
            tx_cnt_d = '0;
            if (!fifo_empty) begin
              pop_c      = 1'b1;
              tx_shift_d = fifo_rd_c;
              tx_cpb_d   = clamp_div(ser.clocks_per_bit);
              tx_state_d = TX_START;
              tx_d       = 1'b0;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Stop sending once only one free slot remains.
  always_comb begin
    rts_d = fifo_full || (fifo_count >= CW'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      sclk_q     <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cpb_q   <= DIV_W'(2);
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_err_q   <= 1'b0;
      push_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cpb_q   <= DIV_W'(2);
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rts_q      <= 1'b0;
    end else begin
      sclk_q     <= ser.serial_clock;
      rx_meta_q  <= ser.rx_pin;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cpb_q   <= rx_cpb_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_err_q   <= rx_err_d;
      push_q     <= push_d;
      tx_state_q <= tx_state_d;
      tx_cpb_q   <= tx_cpb_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rts_q      <= rts_d;
    end
  end

  usart_echo_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (comm_clock),
    .rst_n     (reset_n),
    .push      (push_q),
    .wr_data   (rx_shift_q),
    .pop       (pop_c),
    .rd_data_c (fifo_rd_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ser.tx_pin  = tx_q;
  assign ser.rts_pin = rts_q;

endmodule

// File: tb/tb_usart_echo_unit.sv
// tb_usart_echo_unit: directed bench for usart_echo_unit.
// comm_clock period 10 ns, serial_clock period 4 comm cycles; at 32 ticks per
// bit one serial bit is 128 comm cycles.
`timescale 1ns/1ps
module tb_usart_echo_unit;
  import usart_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int BIT = 128;

  logic comm_clock = 1'b0;
  logic reset_n    = 1'b0;
  int   cyc        = 0;
  int   n_cmp      = 0;
  int   n_bad      = 0;

  usart_echo_unit_if ser ();

  usart_echo_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .comm_clock (comm_clock),
    .reset_n    (reset_n),
    .ser        (ser)
  );

  initial forever #5 comm_clock = ~comm_clock;

  initial begin
    ser.serial_clock = 1'b0;
    #10;
    forever begin
      ser.serial_clock = ~ser.serial_clock;
      #20;
    end
  end

  always @(posedge comm_clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on rx_pin; caller is at a negedge. Line is left at stop_bit.
  task automatic send_byte(input logic [7:0] b, input int bitcyc, input logic stop_bit);
    ser.rx_pin = 1'b0;
    repeat (bitcyc) @(negedge comm_clock);
    for (int i = 0; i < 8; i++) begin
      ser.rx_pin = b[i];
      repeat (bitcyc) @(negedge comm_clock);
    end
    ser.rx_pin = stop_bit;
    repeat (bitcyc) @(negedge comm_clock);
  endtask

  // Wait (bounded) for a start bit on tx_pin and decode the frame at mid-bit.
  task automatic rx_frame(input int bitcyc, input int tmo, output logic [7:0] val,
                          output logic ok, output int fall_at);
    logic s0;
    val     = 8'h00;
    ok      = 1'b0;
    fall_at = -1;
    for (int i = 0; i < tmo; i++) begin
      @(negedge comm_clock);
      if (ser.tx_pin === 1'b0) begin
        fall_at = cyc;
        break;
      end
    end
    if (fall_at < 0) return;
    repeat (bitcyc / 2) @(negedge comm_clock);
    s0 = ser.tx_pin;
    for (int b = 0; b < 8; b++) begin
      repeat (bitcyc) @(negedge comm_clock);
      val[b] = ser.tx_pin;
    end
    repeat (bitcyc) @(negedge comm_clock);
    ok = (s0 === 1'b0) && (ser.tx_pin === 1'b1);
  endtask

  task automatic watch_idle(input int n, output logic saw_low);
    saw_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge comm_clock);
      if (ser.tx_pin !== 1'b1) saw_low = 1'b1;
    end
  endtask

  logic [7:0] v1, v2;
  logic       ok1, ok2, saw, low_seen, rts_seen;
  int         fa, fb, t0;
  logic [7:0] pat [6];
  logic [7:0] rv  [5];
  logic       rok [5];
  int         rf  [5];

  initial begin
    pat[0] = 8'h3C; pat[1] = 8'hA5; pat[2] = 8'h0F;
    pat[3] = 8'hF0; pat[4] = 8'h5A; pat[5] = 8'hE7;
    ser.rx_pin         = 1'b1;
    ser.clocks_per_bit = 12'd32;
    reset_n            = 1'b0;

    // Reset and idle
    low_seen = 1'b0;
    rts_seen = 1'b0;
    for (int i = 0; i < 1020; i++) begin
      @(negedge comm_clock);
      if (i == 19) reset_n = 1'b1;
      if (ser.tx_pin !== 1'b1) low_seen = 1'b1;
      if (ser.rts_pin !== 1'b0) rts_seen = 1'b1;
    end
    check("reset_tx_idle", 32'(low_seen), 32'd0);
    check("reset_rts_low", 32'(rts_seen), 32'd0);

    // Single echo of 0x75
    t0 = cyc;
    fork
      send_byte(8'h75, BIT, 1'b1);
      rx_frame(BIT, 3000, v1, ok1, fa);
    join
    check("echo75_frame", 32'(ok1), 32'd1);
    check("echo75_val", 32'(v1), 32'h75);
    check("echo75_before_stop_end", 32'((fa - t0) < 10 * BIT), 32'd1);
    repeat (300) @(negedge comm_clock);

    // Two frames 100 cycles apart
    fork
      begin
        send_byte(8'h75, BIT, 1'b1);
        repeat (100) @(negedge comm_clock);
        send_byte(8'h8A, BIT, 1'b1);
      end
      begin
        rx_frame(BIT, 3000, v1, ok1, fa);
        rx_frame(BIT, 3000, v2, ok2, fb);
      end
    join
    check("pair_first_frame", 32'(ok1), 32'd1);
    check("pair_first_val", 32'(v1), 32'h75);
    check("pair_second_frame", 32'(ok2), 32'd1);
    check("pair_second_val", 32'(v2), 32'h8A);
    check("pair_gap", 32'((fb - fa) >= 10 * BIT - 3), 32'd1);
    repeat (300) @(negedge comm_clock);

    // Glitch shorter than half a bit
    ser.rx_pin = 1'b0;
    repeat (40) @(negedge comm_clock);
    ser.rx_pin = 1'b1;
    watch_idle(3000, saw);
    check("glitch_no_echo", 32'(saw), 32'd0);
    check("glitch_rts", 32'(ser.rts_pin), 32'd0);

    // Framing error, then a good frame
    fork
      begin
        send_byte(8'h55, BIT, 1'b0);
        repeat (2 * BIT) @(negedge comm_clock);
        ser.rx_pin = 1'b1;
      end
      watch_idle(3000, saw);
    join
    check("framing_no_echo", 32'(saw), 32'd0);
    fork
      send_byte(8'hA3, BIT, 1'b1);
      rx_frame(BIT, 3000, v1, ok1, fa);
    join
    check("after_err_frame", 32'(ok1), 32'd1);
    check("after_err_val", 32'(v1), 32'hA3);
    repeat (300) @(negedge comm_clock);

    // Divisor below 2 behaves as 2 ticks (8 comm cycles) per bit
    ser.clocks_per_bit = 12'd1;
    fork
      send_byte(8'hC6, 8, 1'b1);
      rx_frame(8, 300, v1, ok1, fa);
    join
    check("min_div_frame", 32'(ok1), 32'd1);
    check("min_div_val", 32'(v1), 32'hC6);
    ser.clocks_per_bit = 12'd32;
    repeat (100) @(negedge comm_clock);

    // Slow first echo (256 ticks/bit) so six incoming frames back up the FIFO
    fork
      begin
        for (int k = 0; k < 6; k++) send_byte(pat[k], BIT, 1'b1);
      end
      begin
        repeat (100) @(negedge comm_clock);
        ser.clocks_per_bit = 12'd256;
        repeat (1150) @(negedge comm_clock);
        ser.clocks_per_bit = 12'd32;
        repeat (3690) @(negedge comm_clock);
        check("rts_below_threshold", 32'(ser.rts_pin), 32'd0);
        repeat (380) @(negedge comm_clock);
        check("rts_at_threshold", 32'(ser.rts_pin), 32'd1);
        repeat (3840) @(negedge comm_clock);
        check("rts_while_full", 32'(ser.rts_pin), 32'd1);
      end
      begin
        rx_frame(8 * BIT, 3000, v1, ok1, fa);
        rv[0] = v1; rok[0] = ok1; rf[0] = fa;
        for (int k = 1; k < 5; k++) begin
          rx_frame(BIT, 12000, v1, ok1, fa);
          rv[k] = v1; rok[k] = ok1; rf[k] = fa;
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fill_frame%0d", k), 32'(rok[k]), 32'd1);
      check($sformatf("fill_val%0d", k), 32'(rv[k]), 32'(pat[k]));
    end
    check("fill_gap0", 32'((rf[1] - rf[0]) >= 80 * BIT - 3), 32'd1);
    for (int k = 2; k < 5; k++)
      check($sformatf("fill_gap%0d", k - 1), 32'((rf[k] - rf[k-1]) >= 10 * BIT - 3), 32'd1);
    watch_idle(3000, saw);
    check("dropped_sixth_not_echoed", 32'(saw), 32'd0);
    check("rts_after_drain", 32'(ser.rts_pin), 32'd0);

    // Reset in the middle of an echo
    send_byte(8'h00, BIT, 1'b1);
    repeat (200) @(negedge comm_clock);
    check("midframe_tx_low", 32'(ser.tx_pin), 32'd0);
    reset_n = 1'b0;
    @(posedge comm_clock);
    #1;
    check("midframe_reset_tx", 32'(ser.tx_pin), 32'd1);
    check("midframe_reset_rts", 32'(ser.rts_pin), 32'd0);
    @(negedge comm_clock);
    reset_n = 1'b1;
    watch_idle(2000, saw);
    check("post_reset_idle", 32'(saw), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
